bb_scrambler_par: RTL and testbench
===================================

// Module: bb_scrambler_par
// PURPOSE
//  Parametrised, frame-synchronous baseband scrambler (PRBS 1+x^14+x^15), DATA_W bits per beat.
//  Replaces the bit-serial scrambler on the BBFRAME datapath between frame builder and FEC encoder.
//  Adds a valid/ready handshake, a configurable frame length, bypass mode and frame-length checking.
// PARAMETERS
//  DATA_W      8     bits per beat; data[DATA_W-1] is the earliest bit in time
//  FRAME_BITS  1504  bits per frame; must be a multiple of DATA_W
//  CNT_W       16    width of the frame bit counter; 2**CNT_W > FRAME_BITS
// PORTS
//  clk            in   1       clock; all logic on rising edge
//  reset          in   1       asynchronous, active-high reset
//  initial_state  in   15      LFSR seed, stages s1..s15 = initial_state[14:0]
//  bypass         in   1       1: data passes unscrambled; sampled only at frame start
//  in_valid       in   1       input beat valid
//  in_ready       out  1       block can accept a beat
//  in_data        in   DATA_W  input bits
//  in_sof         in   1       first beat of a frame
//  in_eof         in   1       last beat of a frame
//  out_valid      out  1       output beat valid
//  out_ready      in   1       downstream accepts the beat
//  out_data       out  DATA_W  scrambled bits
//  out_sof        out  1       aligned copy of in_sof
//  out_eof        out  1       aligned copy of in_eof
//  frame_err      out  1       sticky: EOF/SOF misplaced relative to FRAME_BITS
//  err_clr        in   1       synchronous clear of frame_err
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_sof=0, out_eof=0, frame_err=0, lfsr=initial_state,
//    bit count=0, state=IDLE. in_ready=1 once reset is released.
//  Handshake: a beat transfers when valid&ready. in_ready = !out_valid | out_ready.
//    Output stage is a single register, so latency is 1 cycle and full throughput is sustained.
//    Output signals hold stable while out_valid & !out_ready.
//  LFSR step: k = s14^s15; shift s1..s15 right by one; s1 <= k. Key bit = k.
//    One beat applies DATA_W steps combinationally; key bit i is XORed onto data[DATA_W-1-i].
//  FSM IDLE: in_sof&accept -> reload LFSR from initial_state; latch bypass; scramble beat;
//    count=DATA_W; go to FRAME. Accepting a beat without sof is an error: set frame_err,
//    pass the beat through unscrambled (out_sof=0), stay in IDLE.
//  FSM FRAME: each accepted beat advances the LFSR and adds DATA_W to count.
//    - count reaches FRAME_BITS with in_eof=1 -> IDLE.
//    - count reaches FRAME_BITS with in_eof=0 -> set frame_err, go to IDLE.
//    - in_eof=1 before FRAME_BITS -> set frame_err, go to IDLE.
//    - in_sof=1 in FRAME -> set frame_err; treat it as a new frame start (reload, count=DATA_W).
//  Frame with FRAME_BITS==DATA_W: a single beat carrying sof&eof is legal; IDLE->IDLE.
//  bypass latched at 1: out_data = in_data, but LFSR and counter still advance and are still checked.
//  initial_state is read only at the reload. Changing it mid-frame has no effect.
//  LFSR must never be all-zero. initial_state==0 is a misconfiguration; the block does not correct it.
//  err_clr together with a new error in the same cycle: the new error wins, frame_err=1.
//  reset asserted mid-frame: the partial frame is dropped; the next beat must carry sof.
//  No stall/bubble corrupts the LFSR: it advances only on accepted beats.
// TESTING
//  T1 DATA_W=1, seed 15'b100_1010_1000_0000, zero input -> first 8 out bits 0,0,0,0,0,0,1,1.
//  T2 DATA_W=8, same seed, zero input, sof on beat 0 -> first out_data = 8'h03; 188 beats, eof on 188, frame_err=0.
//  T3 DATA_W=8: 50 back-to-back golden frames, random out_ready stalls -> bit-exact match, no lost/duplicated beat.
//  T4 eof on beat 100 of 188 -> frame_err=1 and stays 1; err_clr pulse -> 0; next sof frame correct.
//  T5 bypass=1 at sof -> out_data==in_data for the whole frame; next frame with bypass=0 scrambles from the seed.
//  T6 reset pulse at beat 50 -> all outputs 0 next cycle; following sof frame matches golden from beat 0.

Source files
------------

// File: rtl/bb_scrambler_par.sv
// Frame-synchronous parallel baseband scrambler, PRBS 1+x^14+x^15, DATA_W bits per beat.
// One-register output stage with valid/ready, bypass latched at frame start, sticky frame_err.
module bb_scrambler_par #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FRAME_BITS = 1504,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       initial_state,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eof,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int unsigned    LFSR_W    = 15;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] BEAT_CNT  = CNT_W'(DATA_W);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]    r_count;
  logic                r_bypass;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sof;
  logic                r_out_eof;
  logic                r_frame_err;

  logic                w_accept;
  logic                w_orphan;
  logic                w_byp;
  logic                w_last;
  logic                w_end;
  logic                w_err;
  logic [LFSR_W-1:0]   w_seed;
  logic [LFSR_W-1:0]   w_lfsr_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [DATA_W-1:0]   w_key;
  logic [DATA_W-1:0]   w_data;

  assign in_ready  = !r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign frame_err = r_frame_err;

  // Keystream for one beat: DATA_W LFSR steps, first key bit lands on the MSB.
  // State layout: s1 = bit 14 ... s15 = bit 0.
  always_comb begin
    logic k;
    k           = 1'b0;
    w_seed      = in_sof ? initial_state : r_lfsr;
    w_byp       = in_sof ? bypass : r_bypass;
    w_cnt_next  = (in_sof ? '0 : r_count) + BEAT_CNT;
    w_lfsr_next = w_seed;
    w_key       = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      k           = w_lfsr_next[1] ^ w_lfsr_next[0];
      w_key       = DATA_W'({w_key, k});
      w_lfsr_next = {k, w_lfsr_next[LFSR_W-1:1]};
    end
    w_orphan = (r_state == S_IDLE) && !in_sof;
    w_last   = (w_cnt_next == FRAME_CNT);
    w_end    = w_last | in_eof;
    w_err    = w_orphan | ((r_state == S_FRAME) && in_sof) | (w_last ^ in_eof);
    w_data   = (w_orphan | w_byp) ? in_data : (in_data ^ w_key);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= initial_state;
      r_count     <= '0;
      r_bypass    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sof   <= in_sof;
        r_out_eof   <= in_eof;
        // A beat outside any frame is forwarded raw and leaves the frame state untouched.
        if (!w_orphan) begin
          r_lfsr   <= w_lfsr_next;
          r_bypass <= w_byp;
          r_count  <= w_end ? '0 : w_cnt_next;
          r_state  <= w_end ? S_IDLE : S_FRAME;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_err) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bb_scrambler_par.sv
// Directed bench for bb_scrambler_par: golden frames, stalls, framing errors, bypass, reset.
// Output beats are scoreboarded against an expected queue filled at input acceptance.
module tb_bb_scrambler_par;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FRAME_BITS = 1504;
  localparam int unsigned BEATS      = FRAME_BITS / DATA_W;
  localparam logic [14:0] SEED       = 15'b100_1010_1000_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [14:0]       initial_state;
  logic              bypass;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              in_eof;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_sof;
  logic              out_eof;
  logic              frame_err;
  logic              err_clr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  gk [BEATS];
  logic [9:0]  exp_q [$];
  logic        stall_en = 1'b0;
  logic [9:0]  held;
  logic        held_v = 1'b0;

  always #5 clk = ~clk;

  bb_scrambler_par #(.DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .initial_state(initial_state), .bypass(bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Random downstream backpressure when enabled.
  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Output scoreboard plus stability check while stalled.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold", 32'({out_valid, out_sof, out_eof, out_data}), 32'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({out_sof, out_eof, out_data}), 32'(e));
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_sof, out_eof, out_data};
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input logic [7:0] x);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    exp_q.push_back({s, e, x});
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  // Frame from beat 0; bypass and seed are disturbed after sof to prove they are latched.
  task automatic send_frame(input int nb, input logic with_eof, input logic byp, input logic rnd);
    logic [7:0] d;
    logic [7:0] x;
    for (int j = 0; j < nb; j++) begin
      d = rnd ? 8'($urandom) : 8'h00;
      x = byp ? d : (d ^ gk[j]);
      if (j == 0) begin
        bypass        = byp;
        initial_state = SEED;
      end
      send_beat(d, j == 0, with_eof && (j == nb - 1), x);
      if (j == 0) begin
        bypass        = !byp;
        initial_state = 15'h7FFF;
      end
    end
    bypass        = 1'b0;
    initial_state = SEED;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [14:0] s;
    logic        k;
    reset         = 1'b1;
    initial_state = SEED;
    bypass        = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_sof        = 1'b0;
    in_eof        = 1'b0;
    err_clr       = 1'b0;

    // Bit-serial reference keystream, MSB of each byte earliest.
    s = SEED;
    for (int j = 0; j < int'(BEATS); j++) begin
      for (int b = 7; b >= 0; b--) begin
        k        = s[1] ^ s[0];
        s        = {k, s[14:1]};
        gk[j][b] = k;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_sof", 32'(out_sof), 32'(0));
    check("rst_out_eof", 32'(out_eof), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Zero-data golden frame with hand-computed first two bytes.
    send_beat(8'h00, 1'b1, 1'b0, gk[0]);
    check("t2_beat0", 32'(out_data), 32'(8'h03));
    send_beat(8'h00, 1'b0, 1'b0, gk[1]);
    check("t2_beat1", 32'(out_data), 32'(8'hF6));
    for (int j = 2; j < int'(BEATS); j++)
      send_beat(8'h00, 1'b0, j == int'(BEATS) - 1, gk[j]);
    drain();
    check("t2_frame_err", 32'(frame_err), 32'(0));

    // Back-to-back random frames under backpressure.
    stall_en = 1'b1;
    for (int f = 0; f < 50; f++) send_frame(int'(BEATS), 1'b1, 1'b0, 1'b1);
    drain();
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t3_frame_err", 32'(frame_err), 32'(0));

    // Early eof: sticky error, cleared by err_clr, next frame clean.
    send_frame(100, 1'b1, 1'b0, 1'b1);
    drain();
    check("t4_err_set", 32'(frame_err), 32'(1));
    repeat (5) @(posedge clk);
    #1;
    check("t4_err_sticky", 32'(frame_err), 32'(1));
    clear_err();
    check("t4_err_clr", 32'(frame_err), 32'(0));
    send_frame(int'(BEATS), 1'b1, 1'b0, 1'b1);
    drain();
    check("t4_next_ok", 32'(frame_err), 32'(0));

    // Bypass frame, then a scrambled one from the seed.
    send_frame(int'(BEATS), 1'b1, 1'b1, 1'b1);
    send_frame(int'(BEATS), 1'b1, 1'b0, 1'b1);
    drain();
    check("t5_frame_err", 32'(frame_err), 32'(0));

    // Beat without sof in IDLE passes raw; error beats a same-cycle clear.
    send_beat(8'hA5, 1'b0, 1'b0, 8'hA5);
    drain();
    check("orphan_err", 32'(frame_err), 32'(1));
    err_clr = 1'b1;
    send_beat(8'h5A, 1'b0, 1'b0, 8'h5A);
    err_clr = 1'b0;
    check("clr_vs_err", 32'(frame_err), 32'(1));
    clear_err();
    check("clr_after", 32'(frame_err), 32'(0));

    // Sof inside a frame restarts from the seed and flags an error.
    send_frame(10, 1'b0, 1'b0, 1'b1);
    send_frame(int'(BEATS), 1'b1, 1'b0, 1'b1);
    drain();
    check("midsof_err", 32'(frame_err), 32'(1));

    // Reset mid-frame drops it; the next frame is golden from beat 0.
    send_frame(50, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_out_data", 32'(out_data), 32'(0));
    check("t6_out_sof", 32'(out_sof), 32'(0));
    check("t6_out_eof", 32'(out_eof), 32'(0));
    check("t6_frame_err", 32'(frame_err), 32'(0));
    @(posedge clk);
    #1;
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(int'(BEATS), 1'b1, 1'b0, 1'b0);
    drain();
    check("t6_after_err", 32'(frame_err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
